// File: rtl/mem_writeback_pkg.sv
// Shared definitions for the memory/writeback stage: FSM encoding, funct3 codes,
// latched memory-op record and CSR addresses.
package mem_writeback_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [11:0] CSR_TOHOST = 12'h51E;

    typedef struct packed {
        logic        store;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] addr;
    } mem_op_t;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3[1:0])
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = a[0];
            default: mis = (a != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_writeback_load_align.sv
// Load data alignment: picks the addressed byte/half out of the response word
// and sign- or zero-extends it according to funct3.
module mem_writeback_load_align
    import mem_writeback_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = word;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LHU:  data = {16'h0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_writeback.sv
// Memory/writeback stage: issues loads/stores over a valid/ready request channel,
// aligns load data and drives the regfile write port. Optional tohost CSR: WB_CSR_EN.
module mem_writeback
    import mem_writeback_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RESP_TMO = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd,
    input  logic [2:0]      funct3,
    input  logic            reg_we,
    input  logic            mem_we,
    input  logic            mem_rr,
    input  logic            csr_write,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wmask,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_resp_data,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd,
    output logic            stall,
    output logic            misalign,
    output logic            timeout
`ifdef WB_CSR_EN
    ,
    output logic [XLEN-1:0] csr_tohost
`endif
);

    // Timer width; RESP_TMO == 0 still needs a 1-bit vector to stay legal.
    localparam int TW = (RESP_TMO > 0) ? $clog2(RESP_TMO + 1) : 1;

    logic [1:0]      state_q, state_d;
    mem_op_t         op_q, op_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      wmask_q, wmask_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_wa_q, rf_wa_d;
    logic [XLEN-1:0] rf_wd_q, rf_wd_d;
    logic            misalign_q, misalign_d;
    logic            timeout_q, timeout_d;

    logic            accept;
    logic            is_mem;
    logic            csr_sel;
    logic [3:0]      st_mask;
    logic [XLEN-1:0] st_data;
    logic [XLEN-1:0] ld_data;

`ifdef WB_CSR_EN
    assign csr_sel = csr_write;
`else
    logic unused_csr_write;
    assign csr_sel          = 1'b0;
    assign unused_csr_write = csr_write;
`endif

    assign stall          = (state_q != ST_IDLE);
    assign in_ready       = !stall;
    assign accept         = in_valid & in_ready;
    assign is_mem         = mem_we | mem_rr;

    assign dmem_req_valid = (state_q == ST_REQ);
    assign dmem_we        = op_q.store;
    assign dmem_addr      = {op_q.addr[XLEN-1:2], 2'b00};
    assign dmem_wdata     = wdata_q;
    assign dmem_wmask     = wmask_q;

    assign rf_we          = rf_we_q;
    assign rf_wa          = rf_wa_q;
    assign rf_wd          = rf_wd_q;
    assign misalign       = misalign_q;
    assign timeout        = timeout_q;

    // Byte-lane replication so the memory can take data straight off its lane.
    always_comb begin
        st_mask = 4'b1111;
        st_data = store_data;
        case (funct3[1:0])
            SZ_BYTE: begin
                st_mask = 4'b0001 << alu_result[1:0];
                st_data = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                st_mask = 4'b0011 << alu_result[1:0];
                st_data = {2{store_data[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = store_data;
            end
        endcase
    end

    mem_writeback_load_align u_load_align (
        .addr_lo (op_q.addr[1:0]),
        .funct3  (op_q.funct3),
        .word    (dmem_resp_data),
        .data    (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        tmr_d      = tmr_q;
        rf_we_d    = 1'b0;
        rf_wa_d    = rf_wa_q;
        rf_wd_d    = rf_wd_q;
        misalign_d = 1'b0;
        timeout_d  = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && !csr_sel) begin
                    if (is_mem) begin
                        if (is_misaligned(funct3, alu_result[1:0])) begin
                            misalign_d = 1'b1;
                        end else begin
                            state_d     = ST_REQ;
                            op_d.store  = mem_we & ~mem_rr;
                            op_d.funct3 = funct3;
                            op_d.rd     = rd;
                            op_d.addr   = alu_result;
                            wdata_d     = st_data;
                            wmask_d     = mem_rr ? 4'b0000 : st_mask;
                        end
                    end else if (reg_we) begin
                        rf_we_d = (rd != 5'd0);
                        rf_wa_d = rd;
                        rf_wd_d = alu_result;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_req_ready) begin
                    if (op_q.store) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RESP;
                        tmr_d   = TW'(RESP_TMO);
                    end
                end
            end
            ST_RESP: begin
                // A response in the final timer cycle still wins over the timeout.
                if (dmem_resp_valid) begin
                    rf_we_d = (op_q.rd != 5'd0);
                    rf_wa_d = op_q.rd;
                    rf_wd_d = ld_data;
                    state_d = ST_IDLE;
                end else if (RESP_TMO != 0) begin
                    if (tmr_q == TW'(1)) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        tmr_d = tmr_q - TW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            tmr_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_wa_q    <= '0;
            rf_wd_q    <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            tmr_q      <= tmr_d;
            rf_we_q    <= rf_we_d;
            rf_wa_q    <= rf_wa_d;
            rf_wd_q    <= rf_wd_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef WB_CSR_EN
    logic [XLEN-1:0] csr_tohost_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_tohost_q <= '0;
        end else if (accept && csr_write) begin
            csr_tohost_q <= alu_result;
        end
    end

    assign csr_tohost = csr_tohost_q;
`endif

endmodule

// File: tb/tb_mem_writeback.sv
// Bench for mem_writeback: vector table of ALU/load/store ops with a regfile-write
// scoreboard, plus hand sequences for backpressure, timeout and reset mid-load.
module tb_mem_writeback;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] alu_result, store_data;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        reg_we, mem_we, mem_rr, csr_write;
    logic        dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_data;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        stall, misalign, timeout;

    always #5 clk = ~clk;

    mem_writeback #(.XLEN(32), .RESP_TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .store_data(store_data),
        .rd(rd), .funct3(funct3),
        .reg_we(reg_we), .mem_we(mem_we), .mem_rr(mem_rr), .csr_write(csr_write),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .stall(stall), .misalign(misalign), .timeout(timeout)
    );

    typedef struct {
        logic        reg_we, mem_we, mem_rr;
        logic [2:0]  f3;
        logic [31:0] addr, sdata;
        logic [4:0]  rd;
        logic [31:0] resp;
        logic        exp_mis, exp_rf;
        logic [31:0] exp_wd, exp_daddr;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every regfile write must match the oldest expected write, in order.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            if (sb.size() == 0) begin
                check("rf_we_unexpected", {31'b0, rf_we}, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("rf_wa", {27'b0, rf_wa}, {27'b0, e.wa});
                check("rf_wd", rf_wd, e.wd);
            end
        end
    end

    task automatic clear_inputs();
        in_valid = 0; reg_we = 0; mem_we = 0; mem_rr = 0; csr_write = 0;
    endtask

    task automatic drive_op(input logic rw, input logic mw, input logic mr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [4:0] r);
        in_valid = 1; reg_we = rw; mem_we = mw; mem_rr = mr;
        funct3 = f3; alu_result = a; store_data = sd; rd = r; csr_write = 0;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive_op(v.reg_we, v.mem_we, v.mem_rr, v.f3, v.addr, v.sdata, v.rd);
        if (v.exp_rf) sb.push_back(sb_t'{v.rd, v.exp_wd});
        @(negedge clk);
        clear_inputs();
        check("misalign", {31'b0, misalign}, {31'b0, v.exp_mis});
        if (v.mem_we || v.mem_rr) begin
            if (v.exp_mis) begin
                check("req_valid_misaligned", {31'b0, dmem_req_valid}, 32'd0);
            end else begin
                check("req_valid", {31'b0, dmem_req_valid}, 32'd1);
                check("dmem_addr", dmem_addr, v.exp_daddr);
                check("dmem_we", {31'b0, dmem_we}, {31'b0, v.mem_we && !v.mem_rr});
                if (v.mem_we && !v.mem_rr) begin
                    check("dmem_wmask", {28'b0, dmem_wmask}, {28'b0, v.exp_mask});
                    check("dmem_wdata", dmem_wdata, v.exp_wdata);
                end
                dmem_req_ready = 1;
                @(negedge clk);
                dmem_req_ready = 0;
                if (v.mem_rr) begin
                    check("stall_resp", {31'b0, stall}, 32'd1);
                    dmem_resp_valid = 1;
                    dmem_resp_data  = v.resp;
                    @(negedge clk);
                    dmem_resp_valid = 0;
                end
            end
        end
        @(negedge clk);
        check("stall_idle", {31'b0, stall}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n = 0;
        clear_inputs();
        funct3 = 0; alu_result = 0; store_data = 0; rd = 0;
        dmem_req_ready = 0; dmem_resp_valid = 0; dmem_resp_data = 0;

        //                   rw mw mr f3      addr          sdata         rd     resp          mis rf  exp_wd        daddr         mask     wdata
        vecs.push_back(vec_t'{1, 0, 0, 3'b000, 32'h0000_1234, 32'h0,        5'd5,  32'h0,        0, 1, 32'h0000_1234, 32'h0,        4'h0,    32'h0});
        vecs.push_back(vec_t'{1, 0, 0, 3'b000, 32'h0000_DEAD, 32'h0,        5'd0,  32'h0,        0, 0, 32'h0,        32'h0,        4'h0,    32'h0});
        vecs.push_back(vec_t'{1, 0, 1, 3'b000, 32'h0000_0103, 32'h0,        5'd7,  32'h80FF_0000, 0, 1, 32'hFFFF_FF80, 32'h0000_0100, 4'h0,    32'h0});
        vecs.push_back(vec_t'{1, 0, 1, 3'b101, 32'h0000_0102, 32'h0,        5'd8,  32'h80FF_0000, 0, 1, 32'h0000_80FF, 32'h0000_0100, 4'h0,    32'h0});
        vecs.push_back(vec_t'{1, 0, 1, 3'b001, 32'h0000_0102, 32'h0,        5'd3,  32'h80FF_0000, 0, 1, 32'hFFFF_80FF, 32'h0000_0100, 4'h0,    32'h0});
        vecs.push_back(vec_t'{1, 0, 1, 3'b100, 32'h0000_0101, 32'h0,        5'd4,  32'h1234_A6F0, 0, 1, 32'h0000_00A6, 32'h0000_0100, 4'h0,    32'h0});
        vecs.push_back(vec_t'{1, 0, 1, 3'b010, 32'h0000_0104, 32'h0,        5'd31, 32'hCAFE_BABE, 0, 1, 32'hCAFE_BABE, 32'h0000_0104, 4'h0,    32'h0});
        vecs.push_back(vec_t'{1, 0, 1, 3'b000, 32'h0000_0100, 32'h0,        5'd6,  32'h0000_007F, 0, 1, 32'h0000_007F, 32'h0000_0100, 4'h0,    32'h0});
        vecs.push_back(vec_t'{1, 0, 1, 3'b001, 32'h0000_0106, 32'h0,        5'd2,  32'h7FFF_0001, 0, 1, 32'h0000_7FFF, 32'h0000_0104, 4'h0,    32'h0});
        vecs.push_back(vec_t'{0, 1, 0, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd0,  32'h0,        0, 0, 32'h0,        32'h0000_0200, 4'b1100, 32'hABCD_ABCD});
        vecs.push_back(vec_t'{0, 1, 0, 3'b000, 32'h0000_0301, 32'h0000_005A, 5'd0,  32'h0,        0, 0, 32'h0,        32'h0000_0300, 4'b0010, 32'h5A5A_5A5A});
        vecs.push_back(vec_t'{0, 1, 0, 3'b010, 32'h0000_0404, 32'h1122_3344, 5'd0,  32'h0,        0, 0, 32'h0,        32'h0000_0404, 4'b1111, 32'h1122_3344});
        vecs.push_back(vec_t'{1, 0, 1, 3'b010, 32'h0000_0101, 32'h0,        5'd9,  32'h0,        1, 0, 32'h0,        32'h0,        4'h0,    32'h0});
        vecs.push_back(vec_t'{0, 1, 0, 3'b001, 32'h0000_0203, 32'h0000_1111, 5'd0,  32'h0,        1, 0, 32'h0,        32'h0,        4'h0,    32'h0});
        vecs.push_back(vec_t'{1, 0, 1, 3'b001, 32'h0000_0101, 32'h0,        5'd9,  32'h0,        1, 0, 32'h0,        32'h0,        4'h0,    32'h0});
        vecs.push_back(vec_t'{1, 0, 1, 3'b010, 32'h0000_0108, 32'h0,        5'd0,  32'hFFFF_FFFF, 0, 0, 32'h0,        32'h0000_0108, 4'h0,    32'h0});
        vecs.push_back(vec_t'{1, 1, 1, 3'b010, 32'h0000_010C, 32'hFFFF_FFFF, 5'd9,  32'h55AA_55AA, 0, 1, 32'h55AA_55AA, 32'h0000_010C, 4'h0,    32'h0});

        repeat (2) @(negedge clk);
        check("rst_rf_we",     {31'b0, rf_we},          32'd0);
        check("rst_req_valid", {31'b0, dmem_req_valid}, 32'd0);
        check("rst_stall",     {31'b0, stall},          32'd0);
        check("rst_misalign",  {31'b0, misalign},       32'd0);
        check("rst_timeout",   {31'b0, timeout},        32'd0);
        check("rst_rf_wd",     rf_wd,                   32'd0);
        rst_n = 1;
        @(negedge clk);
        check("in_ready_idle", {31'b0, in_ready}, 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure on a load, with a stray response and new ALU op offered during REQ.
        @(negedge clk);
        drive_op(1, 0, 1, 3'b010, 32'h0000_0600, 32'h0, 5'd10);
        sb.push_back(sb_t'{5'd10, 32'h1357_9BDF});
        @(negedge clk);
        drive_op(1, 0, 0, 3'b000, 32'h0000_0BAD, 32'h0, 5'd11);
        dmem_resp_valid = 1;
        dmem_resp_data  = 32'hDEAD_DEAD;
        for (int i = 0; i < 3; i++) begin
            check("bp_req_valid", {31'b0, dmem_req_valid}, 32'd1);
            check("bp_addr",      dmem_addr,               32'h0000_0600);
            check("bp_stall",     {31'b0, stall},          32'd1);
            check("bp_in_ready",  {31'b0, in_ready},       32'd0);
            @(negedge clk);
        end
        clear_inputs();
        dmem_resp_valid = 0;
        dmem_req_ready  = 1;
        check("bp_req_valid_grant", {31'b0, dmem_req_valid}, 32'd1);
        @(negedge clk);
        dmem_req_ready  = 0;
        dmem_resp_valid = 1;
        dmem_resp_data  = 32'h1357_9BDF;
        @(negedge clk);
        dmem_resp_valid = 0;
        @(negedge clk);
        check("bp_sb_drained", sb.size(), 32'd0);

        // Response timeout: exactly TMO cycles in RESP, then sticky flag.
        @(negedge clk);
        drive_op(1, 0, 1, 3'b010, 32'h0000_0700, 32'h0, 5'd12);
        @(negedge clk);
        clear_inputs();
        dmem_req_ready = 1;
        @(negedge clk);
        dmem_req_ready = 0;
        cyc = 0;
        while (!timeout && cyc < TMO + 8) begin
            @(negedge clk);
            cyc++;
        end
        check("tmo_flag",   {31'b0, timeout}, 32'd1);
        check("tmo_cycles", cyc,              TMO);
        check("tmo_stall",  {31'b0, stall},   32'd0);
        dmem_resp_valid = 1;
        dmem_resp_data  = 32'h0BAD_0BAD;
        @(negedge clk);
        dmem_resp_valid = 0;
        run_vec(vecs[0]);
        check("tmo_sticky", {31'b0, timeout}, 32'd1);

        // Reset while waiting for a load response.
        @(negedge clk);
        drive_op(1, 0, 1, 3'b010, 32'h0000_0800, 32'h0, 5'd13);
        @(negedge clk);
        clear_inputs();
        dmem_req_ready = 1;
        @(negedge clk);
        dmem_req_ready = 0;
        @(negedge clk);
        check("pre_rst_stall", {31'b0, stall}, 32'd1);
        #2 rst_n = 0;
        #1;
        check("mid_rst_stall",     {31'b0, stall},          32'd0);
        check("mid_rst_req_valid", {31'b0, dmem_req_valid}, 32'd0);
        check("mid_rst_timeout",   {31'b0, timeout},        32'd0);
        check("mid_rst_rf_we",     {31'b0, rf_we},          32'd0);
        @(negedge clk);
        rst_n = 1;
        dmem_resp_valid = 1;
        dmem_resp_data  = 32'h7777_7777;
        @(negedge clk);
        dmem_resp_valid = 0;
        check("late_resp_rf_we", {31'b0, rf_we}, 32'd0);
        @(negedge clk);
        check("late_resp_rf_we2", {31'b0, rf_we}, 32'd0);
        check("final_sb_drained", sb.size(),     32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
